// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared constants for the Hamming(15,11) encoder and decoder.
//   DATA_W     : data word width (11)
//   CW_W       : codeword width (15)
//   N_PAR      : number of parity bits (4)
//   PARITY_IDX : codeword bit indices holding parity {0,1,3,7}
//   DATA_POS   : codeword bit index of D1..D11
// Codeword bit i corresponds to Hamming position i+1, so parity bit k sits at
// position 2^k and covers every position whose binary index has bit k set.
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CW_W   = 15;
    localparam int N_PAR  = 4;

    localparam int PARITY_IDX [N_PAR]  = '{0, 1, 3, 7};
    localparam int DATA_POS   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

endpackage : hamming_pkg

// File: rtl/hamming_encoder_15_11.sv
// -----------------------------------------------------------------------------
// hamming_encoder_15_11
// Purely combinational Hamming(15,11) encoder.
// Ports:
//   data     in  [10:0] : D1 at bit 0 .. D11 at bit 10
//   codeword out [14:0] : bit i = Hamming position i+1
// -----------------------------------------------------------------------------
module hamming_encoder_15_11
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   codeword
);

    always_comb begin
        logic p;
        codeword = '0;
        // Scatter data bits into their non-power-of-two positions.
        for (int i = 0; i < DATA_W; i++) begin
            codeword[DATA_POS[i]] = data[i];
        end
        // Parity bit k covers positions (index+1) with bit k set. The other
        // parity positions are never covered by k, so order does not matter.
        for (int k = 0; k < N_PAR; k++) begin
            p = 1'b0;
            for (int j = 0; j < CW_W; j++) begin
                if (((((j + 1) >> k) & 1) == 1) && (j != PARITY_IDX[k])) begin
                    p = p ^ codeword[j];
                end
            end
            codeword[PARITY_IDX[k]] = p;
        end
    end

endmodule : hamming_encoder_15_11

// File: rtl/hamming_enc_stream_15_11.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream_15_11
// Streaming Hamming(15,11) encoder with an inline output FIFO, a delivered-word
// counter and optional single-bit error injection.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer holds data stable while valid && !ready. in_ready depends only on
// registered occupancy (no path from out_ready); out_valid = FIFO not empty.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : 11-bit data input handshake
//   out_codeword/valid/ready : 15-bit codeword output handshake
//   inj_en, inj_pos     : flip codeword bit inj_pos (0..14) of the accepted word
//   word_count          : codewords popped, wrapping
//   inj_count           : errors injected, wrapping
//
// Build option: define HAMMING_ERR_INJECT_EN to enable error injection;
// otherwise inj_en/inj_pos are ignored and inj_count stays 0.
// -----------------------------------------------------------------------------
module hamming_enc_stream_15_11
    import hamming_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CW_W-1:0]   out_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  inj_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CW_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occupancy;

    logic [CW_W-1:0]  enc_cw;
    logic [CW_W-1:0]  inj_mask;
    logic             inj_hit;
    logic             push;
    logic             pop;

    hamming_encoder_15_11 u_encoder (
        .data     (in_data),
        .codeword (enc_cw)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // inj_pos = 15 is the "no error" code: no flip, no count.
    assign inj_hit  = inj_en && (inj_pos != 4'd15);
    assign inj_mask = inj_hit ? (CW_W'(1) << inj_pos) : '0;
`else
    assign inj_hit  = 1'b0;
    assign inj_mask = '0;
    wire unused_inj = &{1'b0, inj_en, inj_pos};
`endif

    assign in_ready     = (occupancy != (PTR_W + 1)'(DEPTH));
    assign out_valid    = (occupancy != '0);
    assign out_codeword = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            word_count <= '0;
            inj_count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_cw ^ inj_mask;
                wr_ptr      <= wr_ptr + 1'b1;
                if (inj_hit) begin
                    inj_count <= inj_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            // Push and pop together leave occupancy unchanged.
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule : hamming_enc_stream_15_11
